// File: rtl/hazard_pkg.sv
// Shared types and constants for the issue-side hazard scoreboard.
// Op-class codes, per-register entry states and the default load latency.
package hazard_pkg;

    localparam logic [1:0] CLASS_ALU  = 2'd0;
    localparam logic [1:0] CLASS_LOAD = 2'd1;
    localparam logic [1:0] CLASS_LONG = 2'd2;

    typedef enum logic [1:0] {
        ST_FREE = 2'd0,
        ST_WAIT = 2'd1,
        ST_LONG = 2'd2
    } entry_st_e;

    localparam int LOAD_LAT_DEF = 1;

endpackage

// File: rtl/hazard_scoreboard_sb_entry.sv
// One scoreboard entry: tracks whether a register is free, counting down
// after a load, or owned by the long unit.
// Ports: clk, rst (sync, active-high), set_load, set_long, clr_long,
//        state_o (current entry state).
module sb_entry
    import hazard_pkg::*;
#(
    parameter int LOAD_LAT = LOAD_LAT_DEF
) (
    input  logic      clk,
    input  logic      rst,
    input  logic      set_load,
    input  logic      set_long,
    input  logic      clr_long,
    output entry_st_e state_o
);

    localparam int CNT_W = (LOAD_LAT < 2) ? 1 : $clog2(LOAD_LAT + 1);

    entry_st_e        state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;

    // A new issue outranks a same-cycle long writeback to this register.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        if (set_load) begin
            state_d = ST_WAIT;
            cnt_d   = CNT_W'(LOAD_LAT);
        end else if (set_long) begin
            state_d = ST_LONG;
        end else if (clr_long && state_q == ST_LONG) begin
            state_d = ST_FREE;
        end else if (state_q == ST_WAIT) begin
            if (cnt_q <= CNT_W'(1)) begin
                state_d = ST_FREE;
                cnt_d   = '0;
            end else begin
                cnt_d = cnt_q - CNT_W'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_FREE;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    assign state_o = state_q;

endmodule

// File: rtl/hazard_scoreboard.sv
// Issue-side hazard scoreboard: stalls ID until each source is forwardable.
// Ports: clk, rst, id_* (ID instruction), flush, long_done/long_rd,
//        stall, issue, long_busy, pending_mask.
// Optional long unit support is enabled by defining SCOREBOARD_LONG_EN.
module hazard_scoreboard
    import hazard_pkg::*;
#(
    parameter int NREGS    = 32,
    parameter int ADDR_W   = 5,
    parameter int LOAD_LAT = LOAD_LAT_DEF
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              id_valid,
    input  logic [ADDR_W-1:0] id_rs1,
    input  logic [ADDR_W-1:0] id_rs2,
    input  logic              id_rs1_used,
    input  logic              id_rs2_used,
    input  logic [ADDR_W-1:0] id_rd,
    input  logic              id_regwrite,
    input  logic [1:0]        id_class,
    input  logic              flush,
    input  logic              long_done,
    input  logic [ADDR_W-1:0] long_rd,
    output logic              stall,
    output logic              issue,
    output logic              long_busy,
    output logic [NREGS-1:0]  pending_mask
);

    entry_st_e  st [NREGS];
    logic       is_load, is_long;
    logic       wr_en;
    logic       haz1, haz2, waw, strct;
    logic       long_busy_q, long_busy_d;

    // Reserved class decodes as ALU.
    assign is_load = (id_class == CLASS_LOAD);
    assign wr_en   = id_regwrite & (id_rd != '0);

    assign haz1 = id_rs1_used & (id_rs1 != '0) & (st[id_rs1] != ST_FREE);
    assign haz2 = id_rs2_used & (id_rs2 != '0) & (st[id_rs2] != ST_FREE);

`ifdef SCOREBOARD_LONG_EN
    assign is_long = (id_class == CLASS_LONG);
    assign waw     = wr_en & (st[id_rd] == ST_LONG);
    assign strct   = is_long & long_busy_q;

    always_comb begin
        long_busy_d = long_busy_q;
        if (long_done)
            long_busy_d = 1'b0;
        if (issue && is_long)
            long_busy_d = 1'b1;
    end
`else
    logic unused_long;
    assign unused_long = ^{long_done, long_rd};
    assign is_long     = 1'b0;
    assign waw         = 1'b0;
    assign strct       = 1'b0;
    assign long_busy_d = 1'b0;
`endif

    assign stall = id_valid & ~flush & (haz1 | haz2 | waw | strct);
    assign issue = id_valid & ~flush & ~stall;

    always_ff @(posedge clk) begin
        if (rst)
            long_busy_q <= 1'b0;
        else
            long_busy_q <= long_busy_d;
    end

    assign long_busy = long_busy_q;

    // x0 is hardwired free.
    assign st[0]           = ST_FREE;
    assign pending_mask[0] = 1'b0;

    for (genvar i = 1; i < NREGS; i++) begin : g_ent
        logic hit_rd;
        logic set_ld, set_lg, clr_lg;

        assign hit_rd = issue & wr_en & (id_rd == ADDR_W'(i));
        assign set_ld = hit_rd & is_load;
        assign set_lg = hit_rd & is_long;
`ifdef SCOREBOARD_LONG_EN
        assign clr_lg = long_done & (long_rd == ADDR_W'(i));
`else
        assign clr_lg = 1'b0;
`endif

        sb_entry #(
            .LOAD_LAT (LOAD_LAT)
        ) u_ent (
            .clk      (clk),
            .rst      (rst),
            .set_load (set_ld),
            .set_long (set_lg),
            .clr_long (clr_lg),
            .state_o  (st[i])
        );

        assign pending_mask[i] = (st[i] != ST_FREE);
    end

endmodule

// File: tb/tb_hazard_scoreboard.sv
// Directed bench for hazard_scoreboard: load-use, flush, reset, x0 and,
// when SCOREBOARD_LONG_EN is defined, long-unit hazards.
module tb_hazard_scoreboard;
    import hazard_pkg::*;

    logic        clk = 1'b0;
    logic        rst;
    logic        id_valid;
    logic [4:0]  id_rs1, id_rs2, id_rd;
    logic        id_rs1_used, id_rs2_used, id_regwrite;
    logic [1:0]  id_class;
    logic        flush;
    logic        long_done;
    logic [4:0]  long_rd;
    logic        stall, issue, long_busy;
    logic [31:0] pending_mask;

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk = ~clk;

    hazard_scoreboard #(
        .NREGS    (32),
        .ADDR_W   (5),
        .LOAD_LAT (1)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .id_valid     (id_valid),
        .id_rs1       (id_rs1),
        .id_rs2       (id_rs2),
        .id_rs1_used  (id_rs1_used),
        .id_rs2_used  (id_rs2_used),
        .id_rd        (id_rd),
        .id_regwrite  (id_regwrite),
        .id_class     (id_class),
        .flush        (flush),
        .long_done    (long_done),
        .long_rd      (long_rd),
        .stall        (stall),
        .issue        (issue),
        .long_busy    (long_busy),
        .pending_mask (pending_mask)
    );

    task automatic check(input string tag,
                         input logic [31:0] got,
                         input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic set_id(input logic v,
                          input logic [4:0] rs1, input logic u1,
                          input logic [4:0] rs2, input logic u2,
                          input logic [4:0] rd, input logic rw,
                          input logic [1:0] cls);
        id_valid    = v;
        id_rs1      = rs1;
        id_rs1_used = u1;
        id_rs2      = rs2;
        id_rs2_used = u2;
        id_rd       = rd;
        id_regwrite = rw;
        id_class    = cls;
    endtask

    task automatic adv();
        @(posedge clk);
        #1;
    endtask

    task automatic smp();
        @(negedge clk);
    endtask

    initial begin
        rst       = 1'b1;
        flush     = 1'b0;
        long_done = 1'b0;
        long_rd   = '0;
        set_id(0, 0, 0, 0, 0, 0, 0, CLASS_ALU);
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;

        smp();
        check("rst_pm", pending_mask, 0);
        check("rst_stall", {31'b0, stall}, 0);
        check("rst_issue", {31'b0, issue}, 0);
        check("rst_busy", {31'b0, long_busy}, 0);

        // ALU producer then ALU consumer: forwarding covers it.
        adv();
        set_id(1, 0, 0, 0, 0, 5, 1, CLASS_ALU);
        smp();
        check("alu_p_issue", {31'b0, issue}, 1);
        adv();
        set_id(1, 5, 1, 0, 0, 6, 1, CLASS_ALU);
        smp();
        check("alu_c_stall", {31'b0, stall}, 0);
        check("alu_c_issue", {31'b0, issue}, 1);
        check("alu_c_pm", pending_mask, 0);

        // Load x3 then consumer on rs2: one stall cycle.
        adv();
        set_id(1, 0, 0, 0, 0, 3, 1, CLASS_LOAD);
        smp();
        check("ld_issue", {31'b0, issue}, 1);
        adv();
        set_id(1, 1, 1, 3, 1, 8, 1, CLASS_ALU);
        smp();
        check("lu_stall", {31'b0, stall}, 1);
        check("lu_issue", {31'b0, issue}, 0);
        check("lu_pm", pending_mask, 32'h8);
        adv();
        smp();
        check("lu2_stall", {31'b0, stall}, 0);
        check("lu2_issue", {31'b0, issue}, 1);
        check("lu2_pm", pending_mask, 0);

        // Unused source on a pending register does not stall.
        adv();
        set_id(1, 0, 0, 0, 0, 4, 1, CLASS_LOAD);
        adv();
        set_id(1, 4, 0, 4, 0, 9, 1, CLASS_ALU);
        smp();
        check("unused_stall", {31'b0, stall}, 0);
        check("unused_pm", pending_mask, 32'h10);

        // Flush with a hazarding instruction in ID.
        adv();
        set_id(1, 0, 0, 0, 0, 3, 1, CLASS_LOAD);
        adv();
        set_id(1, 3, 1, 0, 0, 8, 1, CLASS_ALU);
        flush = 1'b1;
        smp();
        check("fl_stall", {31'b0, stall}, 0);
        check("fl_issue", {31'b0, issue}, 0);
        check("fl_pm", pending_mask, 32'h8);
        adv();
        flush = 1'b0;
        smp();
        check("fl2_issue", {31'b0, issue}, 1);
        check("fl2_pm", pending_mask, 0);

        // Loads to x0 are never tracked.
        adv();
        set_id(1, 0, 0, 0, 0, 0, 1, CLASS_LOAD);
        adv();
        set_id(1, 0, 1, 0, 1, 2, 1, CLASS_ALU);
        smp();
        check("x0_pm", pending_mask, 0);
        check("x0_stall", {31'b0, stall}, 0);

`ifdef SCOREBOARD_LONG_EN
        // Long x7, consumer waits until the cycle after long_done.
        adv();
        set_id(1, 0, 0, 0, 0, 7, 1, CLASS_LONG);
        smp();
        check("lg_issue", {31'b0, issue}, 1);
        adv();
        set_id(1, 7, 1, 0, 0, 10, 1, CLASS_ALU);
        for (int i = 0; i < 6; i++) begin
            smp();
            check("lg_wait_stall", {31'b0, stall}, 1);
            check("lg_wait_busy", {31'b0, long_busy}, 1);
            check("lg_wait_pm", pending_mask, 32'h80);
            adv();
        end
        long_done = 1'b1;
        long_rd   = 5'd7;
        smp();
        check("lg_done_stall", {31'b0, stall}, 1);
        adv();
        long_done = 1'b0;
        smp();
        check("lg_after_issue", {31'b0, issue}, 1);
        check("lg_after_busy", {31'b0, long_busy}, 0);
        check("lg_after_pm", pending_mask, 0);

        // Structural and WAW hazards against a busy long unit.
        adv();
        set_id(1, 0, 0, 0, 0, 7, 1, CLASS_LONG);
        adv();
        set_id(1, 0, 0, 0, 0, 9, 1, CLASS_LONG);
        smp();
        check("struct_stall", {31'b0, stall}, 1);
        set_id(1, 0, 0, 0, 0, 7, 1, CLASS_ALU);
        #1;
        check("waw_stall", {31'b0, stall}, 1);
        adv();
        long_done = 1'b1;
        long_rd   = 5'd7;
        smp();
        check("waw_done_stall", {31'b0, stall}, 1);
        adv();
        long_done = 1'b0;
        smp();
        check("waw_after_issue", {31'b0, issue}, 1);

        // Long op without a destination still occupies the unit.
        adv();
        set_id(1, 0, 0, 0, 0, 0, 0, CLASS_LONG);
        adv();
        set_id(0, 0, 0, 0, 0, 0, 0, CLASS_ALU);
        smp();
        check("lgnw_busy", {31'b0, long_busy}, 1);
        check("lgnw_pm", pending_mask, 0);
        adv();
        long_done = 1'b1;
        long_rd   = 5'd0;
        adv();
        long_done = 1'b0;
        smp();
        check("lgnw_clr", {31'b0, long_busy}, 0);

        // Reset with x7 LONG and x3 WAIT.
        adv();
        set_id(1, 0, 0, 0, 0, 7, 1, CLASS_LONG);
        adv();
        set_id(1, 0, 0, 0, 0, 3, 1, CLASS_LOAD);
        adv();
        set_id(0, 0, 0, 0, 0, 0, 0, CLASS_ALU);
        rst = 1'b1;
        smp();
        check("mr_pm_pre", pending_mask, 32'h88);
        check("mr_busy_pre", {31'b0, long_busy}, 1);
        adv();
        rst = 1'b0;
        smp();
        check("mr_pm", pending_mask, 0);
        check("mr_busy", {31'b0, long_busy}, 0);
`else
        // Reset with x3 WAIT.
        adv();
        set_id(1, 0, 0, 0, 0, 3, 1, CLASS_LOAD);
        adv();
        set_id(0, 0, 0, 0, 0, 0, 0, CLASS_ALU);
        rst = 1'b1;
        smp();
        check("mr_pm_pre", pending_mask, 32'h8);
        adv();
        rst = 1'b0;
        smp();
        check("mr_pm", pending_mask, 0);

        // LONG class degrades to ALU.
        adv();
        set_id(1, 0, 0, 0, 0, 7, 1, CLASS_LONG);
        smp();
        check("nl_issue", {31'b0, issue}, 1);
        adv();
        set_id(1, 7, 1, 0, 0, 11, 1, CLASS_ALU);
        long_done = 1'b1;
        long_rd   = 5'd7;
        smp();
        check("nl_stall", {31'b0, stall}, 0);
        check("nl_busy", {31'b0, long_busy}, 0);
        check("nl_pm", pending_mask, 0);
        adv();
        long_done = 1'b0;
        set_id(1, 0, 0, 0, 0, 12, 1, CLASS_LONG);
        adv();
        set_id(1, 0, 0, 0, 0, 13, 1, CLASS_LONG);
        smp();
        check("nl_struct", {31'b0, stall}, 0);
        check("nl_busy2", {31'b0, long_busy}, 0);
`endif

        adv();
        set_id(0, 0, 0, 0, 0, 0, 0, CLASS_ALU);
        smp();
        check("idle_stall", {31'b0, stall}, 0);
        check("idle_issue", {31'b0, issue}, 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/hazard_scoreboard.md
# hazard_scoreboard

Issue-side hazard controller for the 5-stage RISC pipeline; the producer-tracking counterpart of the forwarding unit. It records, per architectural register, which in-flight instruction will write it and when that result becomes forwardable. It stalls the ID stage when a source operand cannot yet be supplied by the EX/MEM or MEM/WB forwarding paths. It covers load-use hazards and, optionally, a variable-latency multiply/divide unit that writes back out of band.

## Interface
Parameters:
- NREGS, 32, number of architectural registers
- ADDR_W, 5, register index width
- LOAD_LAT, 1, stall cycles a load result needs before it can be forwarded

Ports:
- clk  in  1  clock; all state updates on rising edge
- rst  in  1  reset, synchronous, active-high
- id_valid  in  1  valid instruction in ID
- id_rs1, id_rs2  in  ADDR_W  source register indices
- id_rs1_used, id_rs2_used  in  1  source actually read
- id_rd  in  ADDR_W  destination index
- id_regwrite  in  1  instruction writes id_rd
- id_class  in  2  0=ALU, 1=LOAD, 2=LONG, 3=reserved (treated as ALU)
- flush  in  1  ID instruction squashed this cycle
- long_done  in  1  long unit writes back this cycle
- long_rd  in  ADDR_W  destination of long writeback
- stall  out  1  hold PC/IF/ID, inject bubble into EX
- issue  out  1  ID instruction advances to EX this cycle
- long_busy  out  1  long unit occupied
- pending_mask  out  NREGS  bit i set while register i is not forwardable

## Operation
- Per-register entry states: FREE, WAIT (countdown cnt), LONG.
- Register 0 is never tracked and never stalls.
- hazard_rsN = id_rsN_used & (id_rsN != 0) & entry[id_rsN] != FREE.
- waw = id_regwrite & (id_rd != 0) & entry[id_rd] == LONG.
- struct = id_class == LONG & long_busy.
- stall = id_valid & ~flush & (hazard_rs1 | hazard_rs2 | waw | struct).
- issue = id_valid & ~flush & ~stall.
- On issue with id_regwrite and id_rd != 0:
  - ALU: entry is unchanged (forwarding covers it).
  - LOAD: entry becomes WAIT, cnt = LOAD_LAT.
  - LONG: entry becomes LONG and long_busy is set.
- WAIT entries: cnt decrements each cycle; at cnt == 1 the next state is FREE.
- long_done: entry[long_rd] goes LONG -> FREE and long_busy clears. A long_done for a non-LONG entry is ignored for the entry but still clears long_busy.
- Simultaneous issue writing R and long_done for R: the issue result wins.
- A LONG issue that does not write a register still sets long_busy.
- flush: no state change, issue = 0, stall = 0.

## Timing
- stall, issue and pending_mask are combinational from registered state and ID inputs. No internal path bypasses long_done into stall.
- Reset: every entry FREE, cnt = 0, long_busy = 0, pending_mask = 0. stall and issue reach 0 when id_valid is low.
- Load followed immediately by a consumer: exactly LOAD_LAT stall cycles.
- Long op: the consumer stalls until the cycle after long_done, then issues and takes the value through MEM/WB forwarding.
- Reset asserted mid-operation drops all pending entries on the next edge.

## Configuration
- SCOREBOARD_LONG_EN defined: LONG class, long_busy, waw and struct checks, and long_done handling are present.
- SCOREBOARD_LONG_EN undefined:
  - id_class LONG is treated as ALU.
  - long_busy is tied to 0.
  - long_done and long_rd are ignored.
  - Only load-use hazards stall.

## Structure
- Shared package `hazard_pkg`:
  - op-class constants CLASS_ALU, CLASS_LOAD, CLASS_LONG.
  - entry state encoding ST_FREE, ST_WAIT, ST_LONG.
  - LOAD_LAT default.
- Sub-module `sb_entry`: one per register, instantiated NREGS-1 times via generate. It holds state and cnt, and takes set_load, set_long, clr_long and rst.
- Top level: index decode, hazard compare, stall/issue logic and long_busy flag.

## Test plan
- Reset, then id_valid=1, ALU writing x5, followed by an ALU reading x5 -> stall never 1, issue 1 both cycles, pending_mask=0.
- LOAD writing x3, next instruction reads x3 via rs2 -> stall=1 for 1 cycle, pending_mask[3]=1 for that cycle, issue on the second cycle.
- LONG writing x7, consumer of x7 in ID, long_done/long_rd=7 after 6 cycles -> stall held until the cycle after long_done, long_busy 1 -> 0, then issue.
- Second LONG issued while long_busy, and an ALU writing x7 while x7 is LONG -> stall=1 until long_done; writes to x0 never set pending_mask.
- flush=1 with a hazarding instruction in ID -> stall=0, issue=0, state unchanged; rst asserted with x3 WAIT and x7 LONG -> next cycle pending_mask=0, long_busy=0.
- Build without SCOREBOARD_LONG_EN: LONG writing x7 then a reader of x7 -> no stall, long_busy=0.
